// File: rtl/alu_status_reg_pkg.sv
// Shared processor definitions for the ALU status register.
// ASTAT/STKY bit positions, overflow counter layout, condition codes.
package alu_status_reg_pkg;

    localparam int ASTAT_W = 4;
    localparam int AZ_BIT  = 0;
    localparam int AN_BIT  = 1;
    localparam int AC_BIT  = 2;
    localparam int AV_BIT  = 3;

    localparam int STKY_AVS_BIT = 0;
    localparam int STKY_ACS_BIT = 1;

    localparam int OVCNT_W   = 8;
    localparam int OVCNT_LSB = 8;
    localparam logic [OVCNT_W-1:0] OVCNT_MAX = '1;

    localparam int COND_INV_BIT = 3;

    typedef enum logic [3:0] {
        COND_EQ    = 4'd0,
        COND_LT    = 4'd1,
        COND_LE    = 4'd2,
        COND_AC    = 4'd3,
        COND_AV    = 4'd4,
        COND_AVS   = 4'd5,
        COND_ACS   = 4'd6,
        COND_FALSE = 4'd7,
        COND_NE    = 4'd8,
        COND_GE    = 4'd9,
        COND_GT    = 4'd10,
        COND_NAC   = 4'd11,
        COND_NAV   = 4'd12,
        COND_NAVS  = 4'd13,
        COND_NACS  = 4'd14,
        COND_TRUE  = 4'd15
    } cond_e;

    // Field order mirrors the *_BIT indices above.
    typedef struct packed {
        logic av;
        logic ac;
        logic an;
        logic az;
    } astat_t;

    typedef struct packed {
        logic acs;
        logic avs;
    } stky_t;

endpackage

// File: rtl/alu_status_reg_cond.sv
// Condition-code evaluation over registered ASTAT and sticky flags.
// Purely combinational; bit 3 of the code inverts the base test.
module astat_cond
    import alu_status_reg_pkg::*;
(
    input  astat_t     astat,
    input  stky_t      stky,
    input  logic [3:0] cond,
    output logic       cond_true
);

    logic  base;
    cond_e base_code;

    assign base_code = cond_e'({1'b0, cond[2:0]});

    always_comb begin
        base = 1'b0;
        case (base_code)
            COND_EQ:    base = astat.az;
            COND_LT:    base = astat.an;
            COND_LE:    base = astat.an | astat.az;
            COND_AC:    base = astat.ac;
            COND_AV:    base = astat.av;
            COND_AVS:   base = stky.avs;
            COND_ACS:   base = stky.acs;
            COND_FALSE: base = 1'b0;
            default:    base = 1'b0;
        endcase
    end

    assign cond_true = cond[COND_INV_BIT] ? ~base : base;

endmodule

// File: rtl/alu_status_reg.sv
// ALU status register: ASTAT flag capture, sticky flags, overflow count.
// Flags are captured one cycle after the ALU strobe (en_d).
module alu_status_reg
    import alu_status_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ps_alu_en,
    input  logic                  alu_ps_az,
    input  logic                  alu_ps_an,
    input  logic                  alu_ps_ac,
    input  logic                  alu_ps_av,
    input  logic                  ps_astat_wen,
    input  logic                  ps_stky_clr,
    input  logic [DATA_WIDTH-1:0] xb_dt,
    input  logic [3:0]            ps_cond,
    output logic [DATA_WIDTH-1:0] astat_xb_dt,
    output logic [DATA_WIDTH-1:0] stky_xb_dt,
    output logic                  astat_ps_cond,
    output logic                  astat_ps_busy
);

    logic               en_d;
    astat_t             astat_q, astat_n;
    stky_t              stky_q, stky_n, stky_base;
    logic [OVCNT_W-1:0] ovcnt_q, ovcnt_n, ovcnt_base;
    astat_t             alu_flags;
    logic               unused_xb_hi;

    assign unused_xb_hi = ^xb_dt[DATA_WIDTH-1:ASTAT_W];

    assign alu_flags = '{av: alu_ps_av, ac: alu_ps_ac,
                         an: alu_ps_an, az: alu_ps_az};

    always_comb begin
        astat_n = astat_q;
        if (ps_astat_wen)
            astat_n = astat_t'(xb_dt[ASTAT_W-1:0]);
        else if (en_d)
            astat_n = alu_flags;
    end

    // Clear is applied first so a coincident capture still lands.
    always_comb begin
        stky_base  = ps_stky_clr ? '0 : stky_q;
        ovcnt_base = ps_stky_clr ? '0 : ovcnt_q;
        stky_n     = stky_base;
        ovcnt_n    = ovcnt_base;
        if (en_d) begin
            stky_n.avs = stky_base.avs | alu_ps_av;
            stky_n.acs = stky_base.acs | alu_ps_ac;
            if (alu_ps_av && ovcnt_base != OVCNT_MAX)
                ovcnt_n = ovcnt_base + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_d    <= 1'b0;
            astat_q <= '0;
            stky_q  <= '0;
            ovcnt_q <= '0;
        end else begin
            en_d    <= ps_alu_en;
            astat_q <= astat_n;
            stky_q  <= stky_n;
            ovcnt_q <= ovcnt_n;
        end
    end

    assign astat_ps_busy = en_d;

    always_comb begin
        astat_xb_dt                   = '0;
        astat_xb_dt[ASTAT_W-1:0]      = astat_q;
        stky_xb_dt                    = '0;
        stky_xb_dt[STKY_AVS_BIT]      = stky_q.avs;
        stky_xb_dt[STKY_ACS_BIT]      = stky_q.acs;
        stky_xb_dt[OVCNT_LSB +: OVCNT_W] = ovcnt_q;
    end

    astat_cond u_cond (
        .astat     (astat_q),
        .stky      (stky_q),
        .cond      (ps_cond),
        .cond_true (astat_ps_cond)
    );

endmodule

// File: tb/tb_alu_status_reg.sv
// Self-checking bench for alu_status_reg.
// Directed scenarios plus randomized traffic against a flag-level model.
module tb_alu_status_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps_alu_en;
    logic        alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av;
    logic        ps_astat_wen;
    logic        ps_stky_clr;
    logic [15:0] xb_dt;
    logic [3:0]  ps_cond;
    logic [15:0] astat_xb_dt;
    logic [15:0] stky_xb_dt;
    logic        astat_ps_cond;
    logic        astat_ps_busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_en_d;
    bit m_az, m_an, m_ac, m_av;
    bit m_avs, m_acs;
    int m_cnt;

    always #5 clk = ~clk;

    alu_status_reg #(.DATA_WIDTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .ps_alu_en     (ps_alu_en),
        .alu_ps_az     (alu_ps_az),
        .alu_ps_an     (alu_ps_an),
        .alu_ps_ac     (alu_ps_ac),
        .alu_ps_av     (alu_ps_av),
        .ps_astat_wen  (ps_astat_wen),
        .ps_stky_clr   (ps_stky_clr),
        .xb_dt         (xb_dt),
        .ps_cond       (ps_cond),
        .astat_xb_dt   (astat_xb_dt),
        .stky_xb_dt    (stky_xb_dt),
        .astat_ps_cond (astat_ps_cond),
        .astat_ps_busy (astat_ps_busy)
    );

    function automatic void model_reset();
        m_en_d = 0;
        {m_az, m_an, m_ac, m_av} = '0;
        m_avs = 0;
        m_acs = 0;
        m_cnt = 0;
    endfunction

    function automatic logic [15:0] m_astat();
        return {12'd0, m_av, m_ac, m_an, m_az};
    endfunction

    function automatic logic [15:0] m_stky();
        logic [7:0] c;
        c = 8'(m_cnt);
        return {c, 6'd0, m_acs, m_avs};
    endfunction

    function automatic bit m_cond(input logic [3:0] code);
        bit b;
        case (code[2:0])
            3'd0: b = m_az;
            3'd1: b = m_an;
            3'd2: b = m_an || m_az;
            3'd3: b = m_ac;
            3'd4: b = m_av;
            3'd5: b = m_avs;
            3'd6: b = m_acs;
            default: b = 0;
        endcase
        return code[3] ? !b : b;
    endfunction

    // Drive one cycle of inputs, advance past the edge, update the model.
    task automatic cycle(input bit en, input bit az, input bit an,
                         input bit ac, input bit av, input bit wen,
                         input bit clr, input logic [15:0] xb);
        bit cap;
        ps_alu_en    = en;
        alu_ps_az    = az;
        alu_ps_an    = an;
        alu_ps_ac    = ac;
        alu_ps_av    = av;
        ps_astat_wen = wen;
        ps_stky_clr  = clr;
        xb_dt        = xb;
        @(posedge clk);
        cap    = m_en_d;
        m_en_d = en;
        if (wen)
            {m_av, m_ac, m_an, m_az} = xb[3:0];
        else if (cap)
            {m_av, m_ac, m_an, m_az} = {av, ac, an, az};
        if (clr) begin
            m_avs = 0;
            m_acs = 0;
            m_cnt = 0;
        end
        if (cap) begin
            m_avs = m_avs || av;
            m_acs = m_acs || ac;
            if (av && m_cnt < 255)
                m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 16'h0);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        ps_cond = 4'd0;
        cycle(1, 1, 1, 1, 1, 0, 0, 16'h0);
        model_reset();
        checks++;
        if (astat_xb_dt !== 16'h0 || stky_xb_dt !== 16'h0 ||
            astat_ps_busy !== 1'b0 || astat_ps_cond !== 1'b0) begin
            failures++;
            $display("FAIL reset: astat=%h stky=%h busy=%b cond=%b want 0",
                     astat_xb_dt, stky_xb_dt, astat_ps_busy, astat_ps_cond);
        end
        #3 reset = 1'b0;
        #1;
    endtask

    task automatic test_capture();
        cycle(1, 0, 0, 0, 0, 0, 0, 16'h0);
        cycle(0, 1, 0, 0, 0, 0, 0, 16'h0);
        checks++;
        if (astat_ps_busy !== 1'b0) begin
            failures++;
            $display("FAIL capture_busy_drop: got %b want 0", astat_ps_busy);
        end
        idle();
        checks++;
        if (astat_xb_dt !== 16'h0001) begin
            failures++;
            $display("FAIL capture_astat: got %h want 0001", astat_xb_dt);
        end
    endtask

    task automatic test_busy();
        cycle(1, 0, 0, 0, 0, 0, 0, 16'h0);
        checks++;
        if (astat_ps_busy !== 1'b1) begin
            failures++;
            $display("FAIL busy: got %b want 1", astat_ps_busy);
        end
        idle();
    endtask

    task automatic test_sticky();
        cycle(0, 0, 0, 0, 0, 0, 1, 16'h0);
        cycle(1, 0, 0, 0, 0, 0, 0, 16'h0);
        cycle(1, 0, 0, 1, 1, 0, 0, 16'h0);
        cycle(0, 0, 0, 0, 0, 0, 0, 16'h0);
        checks++;
        if (astat_xb_dt !== 16'h0 || stky_xb_dt !== 16'h0103) begin
            failures++;
            $display("FAIL sticky: astat=%h stky=%h want 0000 0103",
                     astat_xb_dt, stky_xb_dt);
        end
    endtask

    task automatic test_saturate();
        cycle(0, 0, 0, 0, 0, 0, 1, 16'h0);
        for (int i = 0; i < 260; i++)
            cycle(1, 0, 0, 0, 1, 0, 0, 16'h0);
        cycle(0, 0, 0, 0, 1, 0, 0, 16'h0);
        checks++;
        if (stky_xb_dt !== 16'hFF01) begin
            failures++;
            $display("FAIL saturate: got %h want FF01", stky_xb_dt);
        end
        cycle(0, 0, 0, 0, 0, 0, 1, 16'h0);
        checks++;
        if (stky_xb_dt !== 16'h0000) begin
            failures++;
            $display("FAIL stky_clr: got %h want 0000", stky_xb_dt);
        end
    endtask

    task automatic test_clr_capture();
        cycle(0, 0, 0, 0, 0, 0, 1, 16'h0);
        cycle(1, 0, 0, 0, 1, 0, 0, 16'h0);
        cycle(1, 0, 0, 1, 1, 0, 0, 16'h0);
        cycle(0, 0, 0, 0, 1, 0, 1, 16'h0);
        checks++;
        if (stky_xb_dt !== 16'h0101) begin
            failures++;
            $display("FAIL clr_then_set: got %h want 0101", stky_xb_dt);
        end
    endtask

    task automatic test_wen_collide();
        cycle(0, 0, 0, 0, 0, 0, 1, 16'h0);
        cycle(1, 0, 0, 0, 0, 0, 0, 16'h0);
        cycle(0, 1, 0, 0, 0, 1, 0, 16'h000A);
        checks++;
        if (astat_xb_dt !== 16'h000A) begin
            failures++;
            $display("FAIL wen_astat: got %h want 000A", astat_xb_dt);
        end
        checks++;
        if (stky_xb_dt[0] !== 1'b0) begin
            failures++;
            $display("FAIL wen_avs: got %b want 0", stky_xb_dt[0]);
        end
    endtask

    task automatic test_cond_sweep();
        logic [15:0] want;
        want = 16'b1111_1001_0000_0110;
        cycle(0, 0, 0, 0, 0, 1, 1, 16'h0002);
        for (int c = 0; c < 16; c++) begin
            ps_cond = 4'(c);
            #1;
            checks++;
            if (astat_ps_cond !== want[c]) begin
                failures++;
                $display("FAIL cond_sweep[%0d]: got %b want %b",
                         c, astat_ps_cond, want[c]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            ps_cond = 4'($urandom);
            cycle(r[0], r[1], r[2], r[3], r[4],
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 15) == 0),
                  16'($urandom));
            checks++;
            if (astat_xb_dt !== m_astat() || stky_xb_dt !== m_stky() ||
                astat_ps_busy !== m_en_d ||
                astat_ps_cond !== m_cond(ps_cond)) begin
                failures++;
                $display("FAIL random[%0d]: astat=%h/%h stky=%h/%h busy=%b/%b cond=%b/%b",
                         i, astat_xb_dt, m_astat(), stky_xb_dt, m_stky(),
                         astat_ps_busy, m_en_d, astat_ps_cond,
                         m_cond(ps_cond));
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(0, 0, 0, 0, 1, 1, 0, 16'h000F);
        cycle(1, 1, 1, 1, 1, 0, 0, 16'h0);
        ps_cond = 4'd0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (astat_xb_dt !== 16'h0 || stky_xb_dt !== 16'h0 ||
            astat_ps_busy !== 1'b0 || astat_ps_cond !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: astat=%h stky=%h busy=%b cond=%b want 0",
                     astat_xb_dt, stky_xb_dt, astat_ps_busy, astat_ps_cond);
        end
        #1 reset = 1'b0;
        cycle(0, 1, 1, 1, 1, 0, 0, 16'h0);
        cycle(0, 1, 1, 1, 1, 0, 0, 16'h0);
        checks++;
        if (astat_xb_dt !== 16'h0 || stky_xb_dt !== 16'h0) begin
            failures++;
            $display("FAIL reset_no_capture: astat=%h stky=%h want 0",
                     astat_xb_dt, stky_xb_dt);
        end
    endtask

    initial begin
        ps_alu_en    = 0;
        alu_ps_az    = 0;
        alu_ps_an    = 0;
        alu_ps_ac    = 0;
        alu_ps_av    = 0;
        ps_astat_wen = 0;
        ps_stky_clr  = 0;
        xb_dt        = '0;
        ps_cond      = '0;
        reset        = 1'b1;
        model_reset();
        test_reset();
        test_capture();
        test_busy();
        test_sticky();
        test_saturate();
        test_clr_capture();
        test_wen_collide();
        test_cond_sweep();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
